// File: rtl/sram_responder_if.sv
// Initiator-side strobes, address and status of the async SRAM responder.
// The shared data bus stays a plain inout net on the responder itself.
interface sram_responder_if;
  logic [19:0] A;
  logic        CE;
  logic        OE;
  logic        WE;
  logic        UB;
  logic        LB;
  logic        Ready;
  logic        Access_err;

  modport master (
    output A, CE, OE, WE, UB, LB,
    input  Ready, Access_err
  );

  modport slave (
    input  A, CE, OE, WE, UB, LB,
    output Ready, Access_err
  );
endinterface

// File: rtl/sram_responder.sv
// Async-SRAM style responder: 2^AW x 16 array, byte lanes, read latency
// READ_LAT, tri-state data bus, out-of-range flagging.
module sram_responder #(
  parameter int AW       = 10,
  parameter int READ_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_responder_if.slave   io_bus,
  inout  wire  [15:0]       io_mem_bus
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  state_t      r_state;
  state_t      w_state_n;
  logic [19:0] r_addr;
  logic [3:0]  r_cnt;
  logic [15:0] r_rdata;
  logic        r_err;
  logic [15:0] r_mem [2**AW];

  logic        w_rd_req;
  logic        w_wr_req;
  logic        w_oor;
  logic        w_fire_oor;
  logic        w_latch;
  logic        w_fire;
  logic        w_dec;
  logic        w_wr;
  logic [19:0] w_fire_addr;
  logic        w_ready;
  logic        w_oe_hi;
  logic        w_oe_lo;

  assign w_rd_req   = !io_bus.CE && !io_bus.OE && io_bus.WE;
  assign w_wr_req   = !io_bus.CE && !io_bus.WE;
  assign w_oor      = |(io_bus.A >> AW);
  assign w_fire_oor = |(w_fire_addr >> AW);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Write wins over read; a new address while reading restarts the latency.
  always_comb begin
    w_state_n   = r_state;
    w_latch     = 1'b0;
    w_fire      = 1'b0;
    w_dec       = 1'b0;
    w_wr        = 1'b0;
    w_fire_addr = r_addr;
    unique case (r_state)
      IDLE, RD_WAIT, RD_DRIVE: begin
        if (w_wr_req) begin
          w_wr      = 1'b1;
          w_state_n = WR_DONE;
        end else if (!w_rd_req) begin
          w_state_n = IDLE;
        end else if (r_state == IDLE || io_bus.A != r_addr) begin
          w_latch   = 1'b1;
          w_state_n = RD_WAIT;
          if (READ_LAT == 1) begin
            w_fire      = 1'b1;
            w_fire_addr = io_bus.A;
            w_state_n   = RD_DRIVE;
          end
        end else if (r_state == RD_WAIT) begin
          if (r_cnt == 4'd0) begin
            w_fire    = 1'b1;
            w_state_n = RD_DRIVE;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      WR_DONE: begin
        if (!w_wr_req) begin
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_ready = (r_state == RD_DRIVE) || (r_state == WR_DONE);
    w_oe_hi = (r_state == RD_DRIVE) && w_rd_req && !io_bus.UB;
    w_oe_lo = (r_state == RD_DRIVE) && w_rd_req && !io_bus.LB;
  end

  assign io_bus.Ready      = w_ready;
  assign io_bus.Access_err = r_err;

  assign io_mem_bus[15:8] = w_oe_hi ? r_rdata[15:8] : 8'hzz;
  assign io_mem_bus[7:0]  = w_oe_lo ? r_rdata[7:0]  : 8'hzz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= (w_latch || w_wr) && w_oor;
      if (w_latch) begin
        r_addr <= io_bus.A;
        r_cnt  <= LAT_M1;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire) begin
        r_rdata <= w_fire_oor ? 16'hFFFF : r_mem[w_fire_addr[AW-1:0]];
      end
    end
  end

  // Array is never reset; reset also blocks any write on the same edge.
  always_ff @(posedge i_clk) begin
    if (w_wr && !w_oor && !i_rst) begin
      if (!io_bus.UB) begin
        r_mem[io_bus.A[AW-1:0]][15:8] <= io_mem_bus[15:8];
      end
      if (!io_bus.LB) begin
        r_mem[io_bus.A[AW-1:0]][7:0] <= io_mem_bus[7:0];
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: stimulus queues expected Ready and
// Access_err events, a negedge monitor pops and compares them.
module tb_sram_responder;

  localparam int LAT = 2;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [15:0] data;
    logic [1:0]  lanes;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drv_en = 1'b0;
  logic [15:0] drv = '0;
  wire  [15:0] mem_bus;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        prev_rdy = 1'b0;

  exp_t q_rdy[$];
  int   q_err[$];

  sram_responder_if u_if ();

  assign mem_bus = drv_en ? drv : 16'hzzzz;

  sram_responder #(
    .AW       (10),
    .READ_LAT (LAT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .io_bus     (u_if),
    .io_mem_bus (mem_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lmask(logic [1:0] l);
    return {{8{l[1]}}, {8{l[0]}}};
  endfunction

  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] m;
    if (u_if.Ready && !prev_rdy) begin
      if (q_rdy.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdy_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        e = q_rdy.pop_front();
        m = lmask(e.lanes);
        chk("rdy_cycle", cyc, e.cyc);
        chk("bus_lanes", {dut.w_oe_hi, dut.w_oe_lo}, e.lanes);
        if (e.rd) chk("rd_data", mem_bus & m, e.data & m);
      end
    end
    prev_rdy = u_if.Ready;
    if (u_if.Access_err) begin
      if (q_err.size() == 0) begin
        total++;
        bad++;
        $display("FAIL err_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        chk("err_cycle", cyc, q_err.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    u_if.CE = 1'b1;
    u_if.OE = 1'b1;
    u_if.WE = 1'b1;
    u_if.UB = 1'b1;
    u_if.LB = 1'b1;
    drv_en  = 1'b0;
  endtask

  task automatic push_rdy(int c, bit rd, logic [15:0] d, logic [1:0] l);
    exp_t e;
    e.cyc   = c;
    e.rd    = rd;
    e.data  = d;
    e.lanes = l;
    q_rdy.push_back(e);
  endtask

  task automatic set_wr(logic [19:0] a, logic [15:0] d, logic ub, logic lb);
    u_if.A  = a;
    u_if.CE = 1'b0;
    u_if.OE = 1'b1;
    u_if.WE = 1'b0;
    u_if.UB = ub;
    u_if.LB = lb;
    drv     = d;
    drv_en  = 1'b1;
  endtask

  task automatic set_rd(logic [19:0] a, logic ub, logic lb);
    u_if.A  = a;
    u_if.CE = 1'b0;
    u_if.OE = 1'b0;
    u_if.WE = 1'b1;
    u_if.UB = ub;
    u_if.LB = lb;
    drv_en  = 1'b0;
  endtask

  task automatic wr(logic [19:0] a, logic [15:0] d,
                    logic ub, logic lb, bit oor);
    set_wr(a, d, ub, lb);
    push_rdy(cyc + 1, 1'b0, 16'h0, 2'b00);
    if (oor) q_err.push_back(cyc + 1);
    tick();
    idle();
    tick();
  endtask

  task automatic rd(logic [19:0] a, logic ub, logic lb,
                    logic [15:0] d, logic [1:0] l, bit oor);
    set_rd(a, ub, lb);
    push_rdy(cyc + 1 + LAT, 1'b1, d, l);
    if (oor) q_err.push_back(cyc + 1);
    repeat (LAT + 2) tick();
    idle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    u_if.A = '0;
    idle();
    // write held through reset must land on first edge after release
    set_wr(20'h00010, 16'hBEEF, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rst_ready", u_if.Ready, 0);
    chk("rst_err", u_if.Access_err, 0);
    chk("rst_lanes", {dut.w_oe_hi, dut.w_oe_lo}, 0);
    rst = 1'b0;
    push_rdy(cyc + 1, 1'b0, 16'h0, 2'b00);
    tick();
    idle();
    tick();

    rd(20'h00010, 1'b0, 1'b0, 16'hBEEF, 2'b11, 1'b0);
    wr(20'h00020, 16'h1234, 1'b0, 1'b0, 1'b0);

    // address change while driving restarts the read
    set_rd(20'h00010, 1'b0, 1'b0);
    push_rdy(cyc + 1 + LAT, 1'b1, 16'hBEEF, 2'b11);
    repeat (LAT + 2) tick();
    u_if.A = 20'h00020;
    push_rdy(cyc + 1 + LAT, 1'b1, 16'h1234, 2'b11);
    tick();
    chk("reread_rdy_drop", u_if.Ready, 0);
    repeat (LAT + 1) tick();
    idle();
    tick();

    wr(20'h00020, 16'hAB00, 1'b0, 1'b1, 1'b0);
    rd(20'h00020, 1'b0, 1'b0, 16'hAB34, 2'b11, 1'b0);
    rd(20'h00020, 1'b1, 1'b0, 16'h0034, 2'b01, 1'b0);
    wr(20'h00020, 16'h5A5A, 1'b1, 1'b1, 1'b0);
    rd(20'h00020, 1'b0, 1'b0, 16'hAB34, 2'b11, 1'b0);

    wr(20'h00000, 16'h0A0A, 1'b0, 1'b0, 1'b0);
    rd(20'h00400, 1'b0, 1'b0, 16'hFFFF, 2'b11, 1'b1);
    wr(20'h00400, 16'h9999, 1'b0, 1'b0, 1'b1);
    rd(20'h00000, 1'b0, 1'b0, 16'h0A0A, 2'b11, 1'b0);

    // long WE pulse: one write of the first data word only
    set_wr(20'h00040, 16'h1111, 1'b0, 1'b0);
    push_rdy(cyc + 1, 1'b0, 16'h0, 2'b00);
    chk("long_wr_c1", u_if.Ready, 0);
    tick();
    drv = 16'h2222;
    chk("long_wr_c2", u_if.Ready, 1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk("long_wr_cN", u_if.Ready, 1);
    end
    idle();
    tick();
    chk("long_wr_end", u_if.Ready, 0);
    rd(20'h00040, 1'b0, 1'b0, 16'h1111, 2'b11, 1'b0);

    // write aborts a pending read
    set_rd(20'h00010, 1'b0, 1'b0);
    tick();
    chk("abort_wait", u_if.Ready, 0);
    set_wr(20'h00050, 16'h7777, 1'b0, 1'b0);
    u_if.OE = 1'b0;
    push_rdy(cyc + 1, 1'b0, 16'h0, 2'b00);
    tick();
    idle();
    tick();
    rd(20'h00050, 1'b0, 1'b0, 16'h7777, 2'b11, 1'b0);

    // reset in RD_WAIT
    set_rd(20'h00010, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_wait_ready", u_if.Ready, 0);
    chk("rst_wait_lanes", {dut.w_oe_hi, dut.w_oe_lo}, 0);
    idle();
    tick();
    rst = 1'b0;
    tick();

    // reset while driving releases the bus at once
    set_rd(20'h00010, 1'b0, 1'b0);
    push_rdy(cyc + 1 + LAT, 1'b1, 16'hBEEF, 2'b11);
    repeat (LAT + 2) tick();
    chk("drive_lanes", {dut.w_oe_hi, dut.w_oe_lo}, 3);
    rst = 1'b1;
    #1;
    chk("rst_drv_ready", u_if.Ready, 0);
    chk("rst_drv_lanes", {dut.w_oe_hi, dut.w_oe_lo}, 0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    rd(20'h00010, 1'b0, 1'b0, 16'hBEEF, 2'b11, 1'b0);

    repeat (3) tick();
    chk("q_rdy_left", q_rdy.size(), 0);
    chk("q_err_left", q_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter AW, default 10, meaning log2 of implemented word depth (2^AW x 16-bit array).
REQ-002 Parameter READ_LAT, default 2, meaning clock edges from accepted read request to data driven, legal range 1..15.
REQ-003 Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 A  input  20  word address from initiator.
REQ-006 CE  input  1  chip enable, active-low.
REQ-007 OE  input  1  output enable, active-low.
REQ-008 WE  input  1  write enable, active-low.
REQ-009 UB  input  1  upper byte lane [15:8] enable, active-low.
REQ-010 LB  input  1  lower byte lane [7:0] enable, active-low.
REQ-011 Mem_bus  inout  16  shared data bus, driven by this block only during read drive.
REQ-012 Ready  output  1  high while read data valid on Mem_bus or write completed.
REQ-013 Access_err  output  1  one-cycle pulse on out-of-range access.

Function
REQ-014 Read request SHALL be CE=0, OE=0, WE=1; write request SHALL be CE=0, WE=0 (WE overrides OE).
REQ-015 FSM states SHALL be IDLE, RD_WAIT, RD_DRIVE, WR_DONE.
REQ-016 IDLE: read request at edge -> latch A, load counter READ_LAT-1, go RD_WAIT (READ_LAT=1 goes directly RD_DRIVE with data registered).
REQ-017 RD_WAIT: counter decrements each edge; at counter 0 register array word at latched address, go RD_DRIVE.
REQ-018 RD_WAIT/RD_DRIVE: A differs from latched address while read request held -> re-latch, reload counter, go RD_WAIT.
REQ-019 RD_WAIT/RD_DRIVE: read request dropped (CE or OE high) -> go IDLE.
REQ-020 Mem_bus lane SHALL be driven combinationally only when state=RD_DRIVE, CE=0, OE=0, WE=1 and that lane's enable low; otherwise Z (release in same cycle as strobe deassertion).
REQ-021 Write request seen in IDLE, RD_WAIT or RD_DRIVE: at that edge write Mem_bus lanes with UB/LB low into array at A, go WR_DONE; read aborted, bus released.
REQ-022 WR_DONE: no further writes; WE high or CE high -> IDLE; exactly one write per WE assertion.
REQ-023 Write with UB=LB=1 SHALL leave array unchanged but still enter WR_DONE.
REQ-024 Out of range (A[19:AW] nonzero): write suppressed; read data SHALL be 16'hFFFF; Access_err high for the one cycle following the accepting edge.
REQ-025 Ready SHALL be 1 exactly when state is RD_DRIVE or WR_DONE.
REQ-026 CE high SHALL force IDLE on next edge from any state, regardless of OE/WE.

Reset
REQ-027 Reset high SHALL immediately force IDLE, Ready=0, Access_err=0, counter=0, latched address=0, Mem_bus Z.
REQ-028 Array contents SHALL NOT be cleared by Reset; write coincident with Reset SHALL NOT occur.
REQ-029 After Reset release, a request held throughout SHALL be accepted at the first rising edge with Reset low.

Verification
REQ-030 Write A=0x00010, Mem_bus=0xBEEF, UB=LB=0, WE low 1 cycle; then read 0x00010 -> Ready rises 2 edges after acceptance, Mem_bus=0xBEEF.
REQ-031 Write 0x1234 to 0x00020, then UB=0,LB=1 write 0xAB00 -> read returns 0xAB34; read with LB=0,UB=1 -> [7:0]=0x34, [15:8]=Z.
REQ-032 Read A=0x00400 (AW=10) -> Access_err one-cycle pulse, Mem_bus=0xFFFF; write to 0x00400 leaves address 0x000 unchanged.
REQ-033 Hold WE low 5 cycles while Mem_bus changes 0x1111->0x2222 -> only 0x1111 stored, Ready high cycles 2-5.
REQ-034 Assert Reset during RD_WAIT -> Mem_bus Z, Ready 0 immediately; previously written 0xBEEF at 0x00010 still readable after release.
REQ-035 Change A from 0x00010 to 0x00020 mid-RD_DRIVE -> Ready drops, re-reads, returns 0x1234 after READ_LAT edges.
